// File: rtl/osiris_arb_pkg.sv
// -----------------------------------------------------------------------------
// osiris_arb_pkg
// Shared types and helpers for the osiris Wishbone arbiters.
//   arb_state_e : arbiter ownership state (IDLE = 0, OWNED = 1)
//   idx_w(n)    : width of an index into n items, never less than 1
//   timeout_w(c): watchdog counter width able to hold c, clamped to 8..16 bits
// -----------------------------------------------------------------------------
package osiris_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int timeout_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational round-robin picker: returns the first set bit of req found
// when searching upward from index ptr, wrapping at N.
// Ports:
//   req   in  N        request vector
//   ptr   in  idx_w(N) search start index (highest priority)
//   valid out 1        at least one request present
//   idx   out idx_w(N) winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module arb_rr_pick
  import osiris_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic                valid,
  output logic [idx_w(N)-1:0] idx
);

  localparam int IW = idx_w(N);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise paths that skip it infer a latch.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Walk from the farthest offset down so the nearest requester to ptr
    // is the last one written and therefore wins.
    for (int off = N - 1; off >= 0; off--) begin
      int cand;
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
// N-master, single-slave Wishbone arbiter placed in front of an osiris memory.
// Round-robin arbitration from IDLE; the winner keeps the bus for its whole
// Wishbone cycle (until it drops cyc). Losing masters see stall.
//
// Optional build macro WB_ARB_TIMEOUT_EN: adds a watchdog that errors out a
// strobe the slave has not acknowledged within TIMEOUT_CYCLES and releases
// the bus. Without it m_err_o is constant 0 and ownership is unbounded.
//
// Ports (master i uses slice [i*W +: W] of the flattened vectors):
//   clk, rst          clock, synchronous active-high reset
//   m_cyc_i/stb_i/we_i per-master Wishbone controls
//   m_adr_i/dat_i/sel_i per-master address, write data, byte select
//   m_dat_o           read data (broadcast, 0 when no owner)
//   m_ack_o/err_o     per-master acknowledge / timeout error
//   m_stall_o         per-master stall (cyc high but not the owner)
//   s_*               single slave port
//   o_owner           current grant index
//   o_busy            high while a master owns the bus
// -----------------------------------------------------------------------------
module wb_mem_arbiter
  import osiris_arb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0]                m_cyc_i,
  input  logic [N_MASTERS-1:0]                m_stb_i,
  input  logic [N_MASTERS-1:0]                m_we_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [N_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [N_MASTERS-1:0]                m_ack_o,
  output logic [N_MASTERS-1:0]                m_err_o,
  output logic [N_MASTERS-1:0]                m_stall_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  output logic [idx_w(N_MASTERS)-1:0]         o_owner,
  output logic                                o_busy
);

  localparam int IW = idx_w(N_MASTERS);
  localparam int SW = DATA_WIDTH / 8;

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [N_MASTERS-1:0] req;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic                 owned;
  logic                 own_cyc;
  logic                 own_stb;
  logic                 timeout_hit;

  assign req     = m_cyc_i & m_stb_i;
  assign owned   = (state_q == OWNED);
  assign own_cyc = owned & m_cyc_i[gnt_q];
  assign own_stb = own_cyc & m_stb_i[gnt_q];

  arb_rr_pick #(.N(N_MASTERS)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = OWNED;
          gnt_d    = pick_idx;
          rr_ptr_d = (int'(pick_idx) == N_MASTERS - 1) ? '0 : pick_idx + 1'b1;
        end
      end
      OWNED: begin
        // Release is always taken first; any waiting request is arbitrated
        // from IDLE on the following cycle (one turnaround cycle).
        if (!m_cyc_i[gnt_q] || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TIMEOUT_W = timeout_w(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] wd_cnt_q;

  // Counts consecutive strobe cycles without an ack; any ack, strobe drop
  // or expiry restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (timeout_hit || !(own_stb && !s_ack_i)) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = owned && (wd_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;

  // Keeps the watchdog parameter referenced when the watchdog is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
`endif

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (owned) begin
      // On the expiry cycle the slave strobe is withdrawn, so any ack that
      // arrives then is not forwarded alongside the error.
      s_cyc_o          = own_cyc & ~timeout_hit;
      s_stb_o          = own_stb & ~timeout_hit;
      s_we_o           = m_we_i[gnt_q];
      s_adr_o          = m_adr_i[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o          = m_dat_i[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
      s_sel_o          = m_sel_i[int'(gnt_q)*SW +: SW];
      m_dat_o          = s_dat_i;
      m_ack_o[gnt_q]   = s_ack_i & own_stb & ~timeout_hit;
      m_err_o[gnt_q]   = timeout_hit;
    end
  end

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      m_stall_o[i] = m_cyc_i[i] & ~(owned && (gnt_q == IW'(i)));
    end
  end

  assign o_owner = gnt_q;
  assign o_busy  = owned;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
// Self-checking bench for wb_mem_arbiter (2 masters, 32-bit, TIMEOUT_CYCLES=8).
// A cycle-by-cycle vector table covers arbitration, forwarding, stall and
// release; hand-written sequences cover the multi-cycle corner cases. Slave
// transfers are checked by a scoreboard queue filled when a master issues a
// request and drained when the slave side sees an acknowledged strobe.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_stall_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;
  logic [0:0]      o_owner;
  logic            o_busy;

  wb_mem_arbiter #(
    .N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int          master;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t        exp_q[$];
  xfer_t        mon_e;
  logic [N-1:0] mon_ack;
  logic         sb_en = 1'b0;

  task automatic push(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic [31:0] rdata);
    xfer_t e;
    e.master = m; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_en && !rst && s_stb_o && s_ack_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ack", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_ack = '0;
        mon_ack[mon_e.master] = 1'b1;
        check("sb_adr",   s_adr_o, mon_e.adr);
        check("sb_wdat",  s_dat_o, mon_e.dat);
        check("sb_sel",   s_sel_o, mon_e.sel);
        check("sb_we",    s_we_o,  mon_e.we);
        check("sb_ack",   m_ack_o, mon_ack);
        check("sb_rdata", m_dat_o, mon_e.rdata);
      end
    end
  end

  // ------------------------------------------------------------------ helpers
  task automatic set_master(input int m, input logic cyc, input logic stb,
                            input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i[m]            = cyc;
    m_stb_i[m]            = stb;
    m_we_i[m]             = we;
    m_adr_i[m*AW +: AW]   = adr;
    m_dat_i[m*DW +: DW]   = dat;
    m_sel_i[m*SW +: SW]   = sel;
  endtask

  task automatic drop_master(input int m);
    set_master(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop_master(0);
    drop_master(1);
    s_ack_i = 1'b0;
    s_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------- vector table
  typedef struct packed {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       e_scyc;
    logic       e_sstb;
    logic [1:0] e_ack;
    logic [1:0] e_stall;
    logic       e_busy;
    logic       e_owner;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  logic [31:0] exp_adr, exp_dat;
  logic [3:0]  exp_sel;
  logic        exp_we;

  initial begin
    // order: cyc, stb, ack | s_cyc, s_stb, m_ack, stall, busy, owner
    vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1};
    vecs[6]  = '{2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1};
    vecs[7]  = '{2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1};
    vecs[8]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1};
    vecs[9]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

    // ---------------------------------------------------------- reset state
    do_reset();
    sample();
    check("rst_s_cyc", s_cyc_o,   1'b0);
    check("rst_s_stb", s_stb_o,   1'b0);
    check("rst_ack",   m_ack_o,   2'b00);
    check("rst_err",   m_err_o,   2'b00);
    check("rst_stall", m_stall_o, 2'b00);
    check("rst_busy",  o_busy,    1'b0);
    check("rst_owner", o_owner,   1'b0);

    // ------------------------------------------------------ table-driven run
    do_reset();
    set_master(0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_0000, 4'hF);
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h2222_0000, 4'h3);
    s_dat_i = 32'hA5A5_0F0F;
    for (int i = 0; i < NV; i++) begin
      m_cyc_i = vecs[i].cyc;
      m_stb_i = vecs[i].stb;
      s_ack_i = vecs[i].ack;
      exp_adr = !vecs[i].e_busy ? 32'h0 : (vecs[i].e_owner ? 32'h0000_0200 : 32'h0000_0100);
      exp_dat = !vecs[i].e_busy ? 32'h0 : (vecs[i].e_owner ? 32'h2222_0000 : 32'h1111_0000);
      exp_sel = !vecs[i].e_busy ? 4'h0  : (vecs[i].e_owner ? 4'h3 : 4'hF);
      exp_we  = vecs[i].e_busy & ~vecs[i].e_owner;
      sample();
      check($sformatf("v%0d_s_cyc", i), s_cyc_o,   vecs[i].e_scyc);
      check($sformatf("v%0d_s_stb", i), s_stb_o,   vecs[i].e_sstb);
      check($sformatf("v%0d_ack", i),   m_ack_o,   vecs[i].e_ack);
      check($sformatf("v%0d_stall", i), m_stall_o, vecs[i].e_stall);
      check($sformatf("v%0d_busy", i),  o_busy,    vecs[i].e_busy);
      check($sformatf("v%0d_owner", i), o_owner,   vecs[i].e_owner);
      check($sformatf("v%0d_adr", i),   s_adr_o,   exp_adr);
      check($sformatf("v%0d_wdat", i),  s_dat_o,   exp_dat);
      check($sformatf("v%0d_sel", i),   s_sel_o,   exp_sel);
      check($sformatf("v%0d_we", i),    s_we_o,    exp_we);
      check($sformatf("v%0d_rdat", i),  m_dat_o,   vecs[i].e_busy ? 32'hA5A5_0F0F : 32'h0);
      check($sformatf("v%0d_err", i),   m_err_o,   2'b00);
      next_cycle();
    end

    sb_en = 1'b1;

    // ---------------------------------------------------- single master write
    do_reset();
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    push(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0BAD_F00D);
    sample();
    check("wr_stb_not_yet", s_stb_o, 1'b0);
    next_cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0BAD_F00D;
    sample();
    check("wr_stb_rise", s_stb_o, 1'b1);
    check("wr_ack",      m_ack_o, 2'b01);
    next_cycle();
    s_ack_i = 1'b0;
    drop_master(0);
    sample();
    check("wr_release_cyc", s_cyc_o, 1'b0);
    next_cycle();
    sample();
    check("wr_idle", o_busy, 1'b0);

    // -------------------------------------------------------------- contention
    do_reset();
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 4'h3);
    push(0, 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 32'h0000_00AA);
    sample();
    check("ct_both_stalled", m_stall_o, 2'b11);
    next_cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_00AA;
    sample();
    check("ct_owner0",   o_owner,   1'b0);
    check("ct_stall1",   m_stall_o, 2'b10);
    next_cycle();
    s_ack_i = 1'b0;
    drop_master(0);
    sample();
    check("ct_rel_cyc",  s_cyc_o,   1'b0);
    check("ct_rel_busy", o_busy,    1'b1);
    check("ct_rel_stall",m_stall_o, 2'b10);
    next_cycle();
    push(1, 1'b0, 32'h0000_0030, 32'h0000_0000, 4'h3, 32'h0000_00BB);
    sample();
    check("ct_turn_busy", o_busy,    1'b0);
    check("ct_turn_stb",  s_stb_o,   1'b0);
    check("ct_turn_stall",m_stall_o, 2'b10);
    next_cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_00BB;
    sample();
    check("ct_owner1",   o_owner,   1'b1);
    check("ct_stall_m1", m_stall_o, 2'b00);
    next_cycle();
    s_ack_i = 1'b0;
    drop_master(1);
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    sample();
    check("ct_swap_busy", o_busy,  1'b1);
    check("ct_swap_ack",  m_ack_o, 2'b00);
    next_cycle();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'h3);
    sample();
    check("ct_swap_idle", o_busy,    1'b0);
    check("ct2_stalls",   m_stall_o, 2'b11);
    next_cycle();
    sample();
    check("ct2_owner0", o_owner,   1'b0);
    check("ct2_busy",   o_busy,    1'b1);
    check("ct2_stall1", m_stall_o, 2'b10);
    next_cycle();
    drop_master(0);
    drop_master(1);

    // ------------------------------------------------------------ locked burst
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h4040_4040, 4'hC);
    sample();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_0400 + 32'(4*k), 32'h4040_4040 + 32'(k), 4'hC);
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, 4'hF);
      push(1, 1'b1, 32'h0000_0400 + 32'(4*k), 32'h4040_4040 + 32'(k), 4'hC, 32'hB000_0000 + 32'(k));
      s_ack_i = 1'b1;
      s_dat_i = 32'hB000_0000 + 32'(k);
      sample();
      check($sformatf("burst%0d_owner", k), o_owner,   1'b1);
      check($sformatf("burst%0d_stall", k), m_stall_o, 2'b01);
    end
    next_cycle();
    s_ack_i = 1'b0;
    drop_master(1);
    sample();
    check("burst_rel_cyc", s_cyc_o, 1'b0);
    next_cycle();
    sample();
    check("burst_turn_busy",  o_busy,    1'b0);
    check("burst_turn_stall", m_stall_o, 2'b01);
    next_cycle();
    sample();
    check("burst_next_owner", o_owner, 1'b0);
    check("burst_next_busy",  o_busy,  1'b1);
    next_cycle();
    drop_master(0);

    // ------------------------------------------------------ mid-transfer abort
    do_reset();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'hF);
    sample();
    next_cycle();
    sample();
    check("ab_stb", s_stb_o, 1'b1);
    next_cycle();
    drop_master(0);
    s_ack_i = 1'b1;
    sample();
    check("ab_cyc_fall", s_cyc_o, 1'b0);
    check("ab_no_ack",   m_ack_o, 2'b00);
    next_cycle();
    sample();
    check("ab_idle",      o_busy,  1'b0);
    check("ab_late_ack",  m_ack_o, 2'b00);
    next_cycle();
    s_ack_i = 1'b0;

    // -------------------------------------------------------- reset in OWNED
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_0070, 32'h7777_7777, 4'hF);
    s_dat_i = 32'h5555_AAAA;
    sample();
    next_cycle();
    sample();
    check("rm_owned", o_busy,  1'b1);
    check("rm_own1",  o_owner, 1'b1);
    rst = 1'b1;
    next_cycle();
    s_ack_i = 1'b1;
    sample();
    check("rm_s_cyc", s_cyc_o, 1'b0);
    check("rm_s_stb", s_stb_o, 1'b0);
    check("rm_s_adr", s_adr_o, 32'h0);
    check("rm_ack",   m_ack_o, 2'b00);
    check("rm_rdat",  m_dat_o, 32'h0);
    check("rm_busy",  o_busy,  1'b0);
    check("rm_owner", o_owner, 1'b0);
    next_cycle();
    rst = 1'b0;
    s_ack_i = 1'b0;
    drop_master(1);
    next_cycle();

    // ---------------------------------------------------------------- watchdog
    do_reset();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    sample();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      sample();
      check($sformatf("wd_wait%0d_err", c), m_err_o, 2'b00);
      check($sformatf("wd_wait%0d_stb", c), s_stb_o, 1'b1);
    end
    next_cycle();
    sample();
    check("wd_err_pulse", m_err_o, 2'b01);
    check("wd_cyc_off",   s_cyc_o, 1'b0);
    check("wd_stb_off",   s_stb_o, 1'b0);
    next_cycle();
    sample();
    check("wd_released", o_busy,  1'b0);
    check("wd_err_once", m_err_o, 2'b00);
    next_cycle();
    sample();
    check("wd_regrant", o_busy, 1'b1);
`else
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      sample();
      check($sformatf("hold%0d_err", c), m_err_o, 2'b00);
    end
    check("hold_busy", o_busy,  1'b1);
    check("hold_stb",  s_stb_o, 1'b1);
`endif
    next_cycle();
    drop_master(0);
    next_cycle();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
